// File: rtl/mem_stream_reader_if.sv
// Memory-read and output-stream signals of mem_stream_reader.
// Optional m_last appears only when MEM_STREAM_READER_LAST_EN is defined.
interface mem_stream_reader_if #(
   parameter int W  = 8,
   parameter int DW = 7
);
   logic [DW-1:0] mem_addr;
   logic [W-1:0]  mem_dout;
   logic [W-1:0]  m_data;
   logic          m_valid;
   logic          m_ready;
`ifdef MEM_STREAM_READER_LAST_EN
   logic          m_last;

   modport master (output mem_addr, m_data, m_valid, m_last, input mem_dout, m_ready);
   modport slave  (input mem_addr, m_data, m_valid, m_last, output mem_dout, m_ready);
`else
   modport master (output mem_addr, m_data, m_valid, input mem_dout, m_ready);
   modport slave  (input mem_addr, m_data, m_valid, output mem_dout, m_ready);
`endif
endinterface

// File: rtl/mem_stream_reader.sv
// Burst reader: fetches len words from a sync-read memory and streams them out with backpressure.
// Optional feature macro MEM_STREAM_READER_LAST_EN adds m_last on the final word.
//
// state | meaning
// IDLE  | waiting for start; ptr holds its last value
// READ  | issuing reads while the 2-entry buffer has room
// DRAIN | all reads issued; emptying buffer until the last word is taken
module mem_stream_reader #(
   parameter int  W  = 8,
   parameter int  D  = 128,
   localparam int DW = $clog2(D)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] base_addr,
   input  logic [DW:0]   len,
   output logic          busy,
   output logic          done,
   mem_stream_reader_if.master bus
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t        state_q,     state_d;
   logic [DW-1:0] ptr_q,       ptr_d;
   logic [DW:0]   issue_cnt_q, issue_cnt_d;
   logic [DW:0]   out_cnt_q,   out_cnt_d;
   logic          inflight_q,  inflight_d;
   logic [1:0]    occ_q,       occ_d;
   logic [W-1:0]  buf0_q,      buf0_d;
   logic [W-1:0]  buf1_q,      buf1_d;
   logic          done_q,      done_d;

   logic pop;
   logic issue_en;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      issue_cnt_d = issue_cnt_q;
      out_cnt_d   = out_cnt_q;
      occ_d       = occ_q;
      buf0_d      = buf0_q;
      buf1_d      = buf1_q;
      done_d      = 1'b0;

      pop = (occ_q != 2'd0) && bus.m_ready;
      // Only issue when the returning word is guaranteed a buffer slot.
      issue_en = (state_q == READ) && (issue_cnt_q != '0) &&
                 ((({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2) || pop);
      inflight_d = issue_en;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  state_d     = READ;
                  ptr_d       = base_addr;
                  issue_cnt_d = len;
                  out_cnt_d   = len;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         READ: begin
            if (issue_en) begin
               ptr_d       = (ptr_q == DW'(D - 1)) ? '0 : ptr_q + 1'b1;
               issue_cnt_d = issue_cnt_q - 1'b1;
               if (issue_cnt_q == (DW + 1)'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && out_cnt_q == (DW + 1)'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) out_cnt_d = out_cnt_q - 1'b1;

      // buf0 is the head; buf1 is only meaningful when occ == 2.
      case ({inflight_q, pop})
         2'b11: begin
            if (occ_q == 2'd2) begin
               buf0_d = buf1_q;
               buf1_d = bus.mem_dout;
            end else begin
               buf0_d = bus.mem_dout;
            end
         end
         2'b10: begin
            if (occ_q == 2'd0) buf0_d = bus.mem_dout;
            else               buf1_d = bus.mem_dout;
            occ_d = occ_q + 1'b1;
         end
         2'b01: begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         issue_cnt_q <= '0;
         out_cnt_q   <= '0;
         inflight_q  <= 1'b0;
         occ_q       <= 2'd0;
         buf0_q      <= '0;
         buf1_q      <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         issue_cnt_q <= issue_cnt_d;
         out_cnt_q   <= out_cnt_d;
         inflight_q  <= inflight_d;
         occ_q       <= occ_d;
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
         done_q      <= done_d;
      end
   end

   assign busy         = (state_q != IDLE);
   assign done         = done_q;
   assign bus.mem_addr = ptr_q;
   assign bus.m_data   = buf0_q;
   assign bus.m_valid  = (occ_q != 2'd0);
`ifdef MEM_STREAM_READER_LAST_EN
   assign bus.m_last   = (occ_q != 2'd0) && (out_cnt_q == (DW + 1)'(1));
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a behavioural sync-read memory.
module tb_mem_stream_reader;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [6:0] base_addr;
   logic [7:0] len;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;
   int first_valid;
   int last_issued;
   int addr_log [0:63];

   logic [7:0] mem [0:127];

   mem_stream_reader_if #(.W(8), .DW(7)) bus ();

   mem_stream_reader #(.W(8), .D(128)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) bus.mem_dout <= mem[bus.mem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic start_burst(input int b, input int l);
      start     = 1'b1;
      base_addr = 7'(b);
      len       = 8'(l);
      @(negedge clk);
      start     = 1'b0;
   endtask

   // mode 0: ready high; 1: alternate then 5-cycle stall; 2: ready high + extra start; 3: stall on 3rd word
   task automatic drain(input int base, input int blen, input int n, input int mode);
      int         idx, cyc, issued;
      logic       held, over;
      logic [7:0] held_data, exp_d;
      logic [6:0] prev;
      idx = 0; cyc = 0; issued = 0; held = 0; over = 0; held_data = '0;
      first_valid = -1;
      prev = bus.mem_addr;
      while (idx < n && cyc < 300) begin
         if (bus.mem_addr != prev) begin
            if (issued < 64) addr_log[issued] = int'(prev);
            issued++;
            prev = bus.mem_addr;
         end
         if (issued - idx > 2) over = 1'b1;
         case (mode)
            1:       bus.m_ready = (cyc < 10) ? (cyc % 2 == 0) : (cyc >= 15);
            3:       bus.m_ready = !(cyc >= 4 && cyc < 7);
            default: bus.m_ready = 1'b1;
         endcase
         if (mode == 2) begin
            if (cyc == 3) begin
               start = 1'b1; base_addr = 7'h50; len = 8'd5;
            end else begin
               start = 1'b0;
            end
         end
`ifdef MEM_STREAM_READER_LAST_EN
         chk("m_last", 32'(bus.m_last), 32'(bus.m_valid && (idx == blen - 1)));
`endif
         if (bus.m_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (held) chk("hold_stable", 32'(bus.m_data), 32'(held_data));
            if (bus.m_ready) begin
               exp_d = mem[(base + idx) % 128];
               chk("data", 32'(bus.m_data), 32'(exp_d));
               idx++;
               held = 1'b0;
            end else begin
               held      = 1'b1;
               held_data = bus.m_data;
            end
         end
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      if (idx < n) chk("timeout_words", 32'(idx), 32'(n));
      chk("over_issue", 32'(over), 32'd0);
      last_issued = issued;
   endtask

   task automatic check_done();
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_end", 32'(busy), 32'd0);
      chk("valid_end", 32'(bus.m_valid), 32'd0);
      @(negedge clk);
      chk("done_clear", 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'(i + 16);
      rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; bus.m_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_data", 32'(bus.m_data), 32'd0);
      chk("rst_addr", 32'(bus.mem_addr), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // basic burst
      start_burst(4, 8);
      chk("busy_start", 32'(busy), 32'd1);
      drain(4, 8, 8, 0);
      chk("first_valid_lat", 32'(first_valid), 32'd2);
      check_done();

      // wrap-around
      start_burst(126, 4);
      drain(126, 4, 4, 0);
      chk("issued_wrap", 32'(last_issued), 32'd4);
      chk("addr0", 32'(addr_log[0]), 32'd126);
      chk("addr1", 32'(addr_log[1]), 32'd127);
      chk("addr2", 32'(addr_log[2]), 32'd0);
      chk("addr3", 32'(addr_log[3]), 32'd1);
      check_done();

      // backpressure
      start_burst(10, 16);
      drain(10, 16, 16, 1);
      chk("issued_bp", 32'(last_issued), 32'd16);
      check_done();

      // zero length
      start_burst(5, 0);
      chk("zl_done", 32'(done), 32'd1);
      chk("zl_busy", 32'(busy), 32'd0);
      chk("zl_valid", 32'(bus.m_valid), 32'd0);
      @(negedge clk);
      chk("zl_done_clear", 32'(done), 32'd0);
      chk("zl_busy2", 32'(busy), 32'd0);
      chk("zl_valid2", 32'(bus.m_valid), 32'd0);

      // start while busy is ignored
      start_burst(32, 8);
      drain(32, 8, 8, 2);
      chk("issued_sb", 32'(last_issued), 32'd8);
      check_done();
      chk("sb_busy_after", 32'(busy), 32'd0);
      chk("sb_valid_after", 32'(bus.m_valid), 32'd0);

      // reset mid-burst
      start_burst(48, 10);
      drain(48, 10, 3, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_valid", 32'(bus.m_valid), 32'd0);
      chk("mr_done", 32'(done), 32'd0);
      chk("mr_addr", 32'(bus.mem_addr), 32'd0);
      @(negedge clk);
      chk("mr_no_done", 32'(done), 32'd0);
      start_burst(0, 2);
      drain(0, 2, 2, 0);
      check_done();

      // stall on the final word
      start_burst(64, 3);
      drain(64, 3, 3, 3);
      check_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
